// File: rtl/cpu_axi_pkg.sv
// Shared constants and helpers for the SRAM-like to AXI3 bridge.
// Fixed AXI attributes, port IDs, byte-strobe and clog2 helpers.
package cpu_axi_pkg;

    localparam int INST_ID = 0;
    localparam int DATA_ID = 1;

    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    function automatic logic [3:0] size_to_wstrb(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << off;
            2'd1:    s = 4'b0011 << {off[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_ot_slot.sv
// One-entry request register for an AXI address/data channel.
// free is high when the slot may take a new entry this cycle.
module axi_req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         ready,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_axi_bridge_ot.sv
// SRAM-like inst/data ports to one AXI3 master, several reads/writes in flight.
// Data reads and writes never overlap, so data responses stay in order.
module cpu_axi_bridge_ot
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_OT  = 4,
    parameter int WR_OT  = 4,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int RCW = clog2(RD_OT + 1);
    localparam int WCW = clog2(WR_OT + 1);
    localparam logic [RCW-1:0] RD_MAX = RCW'(RD_OT);
    localparam logic [WCW-1:0] WR_MAX = WCW'(WR_OT);
    localparam int ARW = ADDR_W + 3;

    logic [RCW-1:0] inst_rd_cnt, data_rd_cnt;
    logic [WCW-1:0] wr_cnt;

    logic ar_free, aw_free, w_free;
    logic ar_load, ar_is_data;
    logic data_rd_ok, data_wr_ok, inst_rd_ok;
    logic [ARW-1:0] ar_din, ar_q;
    logic [ADDR_W-1:0] aw_din, aw_q;
    logic [35:0] w_din, w_q;

    logic r_inst_hit, r_data_hit;
    logic inst_dec, data_dec, wr_dec;
    logic r_ok_q, b_ok_q;
    logic [ID_W-1:0] r_id_q;
    logic [31:0] r_data_q;

    logic unused_in;
    assign unused_in = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

    // Read/write exclusion on the data port keeps its responses ordered
    assign data_rd_ok = data_req && !data_wr && ar_free
                     && (data_rd_cnt < RD_MAX) && (wr_cnt == '0)
                     && !awvalid && !wvalid;
    assign inst_rd_ok = inst_req && ar_free
                     && (inst_rd_cnt < RD_MAX) && !data_rd_ok;
    assign data_wr_ok = data_req && data_wr && aw_free && w_free
                     && (wr_cnt < WR_MAX) && (data_rd_cnt == '0)
                     && !(arvalid && ar_is_data);

    assign inst_addr_ok = inst_rd_ok;
    assign data_addr_ok = data_rd_ok || data_wr_ok;

    assign ar_load = data_rd_ok || inst_rd_ok;
    assign ar_din  = data_rd_ok ? {1'b1, data_addr, data_size}
                                : {1'b0, inst_addr, inst_size};
    assign aw_din  = {data_addr[ADDR_W-1:2], 2'b00};
    assign w_din   = {data_wdata,
                      size_to_wstrb(data_size, data_addr[1:0])};

    axi_req_slot #(.W(ARW)) u_ar (
        .clk(clk), .reset(reset), .load(ar_load), .ready(arready),
        .din(ar_din), .valid(arvalid), .dout(ar_q), .free(ar_free)
    );

    axi_req_slot #(.W(ADDR_W)) u_aw (
        .clk(clk), .reset(reset), .load(data_wr_ok), .ready(awready),
        .din(aw_din), .valid(awvalid), .dout(aw_q), .free(aw_free)
    );

    axi_req_slot #(.W(36)) u_w (
        .clk(clk), .reset(reset), .load(data_wr_ok), .ready(wready),
        .din(w_din), .valid(wvalid), .dout(w_q), .free(w_free)
    );

    // awsize tracks the accepted size; it is sampled from the same request
    logic [1:0] aw_size_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            aw_size_q <= 2'b00;
        else if (data_wr_ok)
            aw_size_q <= data_size;
    end

    assign ar_is_data = ar_q[ARW-1];
    assign arid    = ar_is_data ? ID_W'(DATA_ID) : ID_W'(INST_ID);
    assign araddr  = ar_q[ADDR_W+1:2];
    assign arsize  = {1'b0, ar_q[1:0]};
    assign arlen   = 8'd0;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;

    assign awid    = ID_W'(DATA_ID);
    assign awaddr  = aw_q;
    assign awsize  = {1'b0, aw_size_q};
    assign awlen   = 8'd0;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;

    assign wid   = ID_W'(DATA_ID);
    assign wdata = w_q[35:4];
    assign wstrb = w_q[3:0];
    assign wlast = 1'b1;

    assign rready = 1'b1;
    assign bready = 1'b1;

    assign r_inst_hit = rvalid && (rid == ID_W'(INST_ID));
    assign r_data_hit = rvalid && (rid != ID_W'(INST_ID));
    assign inst_dec = r_inst_hit && (inst_rd_cnt != '0);
    assign data_dec = r_data_hit && (data_rd_cnt != '0);
    assign wr_dec   = bvalid && (wr_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_rd_cnt <= '0;
            data_rd_cnt <= '0;
            wr_cnt      <= '0;
        end else begin
            if (inst_rd_ok != inst_dec)
                inst_rd_cnt <= inst_rd_ok ? inst_rd_cnt + RCW'(1)
                                          : inst_rd_cnt - RCW'(1);
            if (data_rd_ok != data_dec)
                data_rd_cnt <= data_rd_ok ? data_rd_cnt + RCW'(1)
                                          : data_rd_cnt - RCW'(1);
            if (data_wr_ok != wr_dec)
                wr_cnt <= data_wr_ok ? wr_cnt + WCW'(1)
                                     : wr_cnt - WCW'(1);
            assert (!(r_inst_hit && inst_rd_cnt == '0));
            assert (!(r_data_hit && data_rd_cnt == '0));
            assert (!(bvalid && wr_cnt == '0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ok_q   <= 1'b0;
            b_ok_q   <= 1'b0;
            r_id_q   <= '0;
            r_data_q <= '0;
        end else begin
            r_ok_q <= rvalid;
            b_ok_q <= bvalid;
            if (rvalid) begin
                r_id_q   <= rid;
                r_data_q <= rdata;
            end
        end
    end

    assign inst_data_ok = r_ok_q && (r_id_q == ID_W'(INST_ID));
    assign data_data_ok = (r_ok_q && (r_id_q != ID_W'(INST_ID))) || b_ok_q;
    assign inst_rdata   = r_data_q;
    assign data_rdata   = r_data_q;

endmodule

// File: tb/tb_cpu_axi_bridge_ot.sv
// Directed bench for cpu_axi_bridge_ot with a small AXI slave model.
// Slave returns rdata = araddr ^ 32'hCAFE0000, B one cycle after AW and W.
module tb_cpu_axi_bridge_ot;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 2;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 2;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 1, awready = 1, wready = 1;
    logic [3:0]  rid = 0, bid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic        rlast = 1, rvalid = 0, bvalid = 0;

    int n_cmp = 0;
    int n_err = 0;

    cpu_axi_bridge_ot dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          due;
    } rq_t;

    rq_t rq[$];
    int e = 0, aw_n = 0, w_n = 0, b_n = 0;

    // R returns two edges after the AR handshake; B one edge after AW+W
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rq.delete();
            rvalid <= 0;
            bvalid <= 0;
            e <= 0;
            aw_n <= 0;
            w_n <= 0;
            b_n <= 0;
        end else begin
            e <= e + 1;
            rvalid <= 0;
            if (rq.size() > 0 && rq[0].due <= e) begin
                rvalid <= 1;
                rid <= rq[0].id;
                rdata <= rq[0].addr ^ 32'hCAFE0000;
                rq.pop_front();
            end
            if (arvalid && arready)
                rq.push_back('{arid, araddr, e + 2});
            bvalid <= 0;
            if (aw_n > b_n && w_n > b_n) begin
                bvalid <= 1;
                b_n <= b_n + 1;
            end
            if (awvalid && awready) aw_n <= aw_n + 1;
            if (wvalid && wready) w_n <= w_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 1);
        chk("rst_bready", bready, 1);
        chk("rst_iok", inst_data_ok, 0);
        chk("rst_dok", data_data_ok, 0);
        chk("rst_iaok", inst_addr_ok, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arburst", arburst, 1);
        chk("rst_wlast", wlast, 1);
        chk("rst_awid", awid, 1);
        nxt();
        reset = 0;

        // 1: four back-to-back inst reads, fifth stalls
        nxt();
        inst_req = 1;
        inst_addr = 32'h1000;
        mid();
        chk("t1_aok0", inst_addr_ok, 1);
        chk("t1_arv0", arvalid, 0);
        for (int i = 1; i < 4; i++) begin
            nxt();
            inst_addr = 32'h1000 + 32'(4 * i);
            mid();
            chk("t1_aok", inst_addr_ok, 1);
            chk("t1_arv", arvalid, 1);
            chk("t1_araddr", araddr, 32'h1000 + 32'(4 * (i - 1)));
            chk("t1_arid", arid, 0);
        end
        nxt();
        inst_addr = 32'h1010;
        mid();
        chk("t1_full", inst_addr_ok, 0);
        chk("t1_araddr3", araddr, 32'h100C);
        chk("t1_nok", inst_data_ok, 0);
        nxt();
        mid();
        chk("t1_drain", inst_addr_ok, 1);
        chk("t1_arv_idle", arvalid, 0);
        chk("t1_ok0", inst_data_ok, 1);
        chk("t1_rd0", inst_rdata, 32'hCAFE1000);
        nxt();
        inst_req = 0;
        mid();
        chk("t1_araddr4", araddr, 32'h1010);
        chk("t1_ok1", inst_data_ok, 1);
        chk("t1_rd1", inst_rdata, 32'hCAFE1004);
        nxt();
        mid();
        chk("t1_ok2", inst_data_ok, 1);
        chk("t1_rd2", inst_rdata, 32'hCAFE1008);
        nxt();
        mid();
        chk("t1_ok3", inst_data_ok, 1);
        chk("t1_rd3", inst_rdata, 32'hCAFE100C);
        nxt();
        mid();
        chk("t1_gap", inst_data_ok, 0);
        nxt();
        mid();
        chk("t1_ok4", inst_data_ok, 1);
        chk("t1_rd4", inst_rdata, 32'hCAFE1010);
        chk("t1_dquiet", data_data_ok, 0);

        // 2: simultaneous inst and data read, data wins
        nxt();
        inst_req = 1;
        inst_addr = 32'h3000;
        data_req = 1;
        data_wr = 0;
        data_size = 2;
        data_addr = 32'h4000;
        mid();
        chk("t2_daok", data_addr_ok, 1);
        chk("t2_iaok", inst_addr_ok, 0);
        nxt();
        data_req = 0;
        mid();
        chk("t2_iaok1", inst_addr_ok, 1);
        chk("t2_arid_d", arid, 1);
        chk("t2_araddr_d", araddr, 32'h4000);
        chk("t2_arsize", arsize, 2);
        nxt();
        inst_req = 0;
        mid();
        chk("t2_arid_i", arid, 0);
        chk("t2_araddr_i", araddr, 32'h3000);
        nxt();
        nxt();
        nxt();
        mid();
        chk("t2_dok", data_data_ok, 1);
        chk("t2_drd", data_rdata, 32'hCAFE4000);
        chk("t2_inok", inst_data_ok, 0);
        nxt();
        mid();
        chk("t2_iok", inst_data_ok, 1);
        chk("t2_ird", inst_rdata, 32'hCAFE3000);
        chk("t2_dnok", data_data_ok, 0);

        // 3: byte store to 0x2003
        nxt();
        data_req = 1;
        data_wr = 1;
        data_size = 0;
        data_addr = 32'h2003;
        data_wdata = 32'h000000AB;
        mid();
        chk("t3_aok", data_addr_ok, 1);
        nxt();
        data_req = 0;
        mid();
        chk("t3_awv", awvalid, 1);
        chk("t3_wv", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h2000);
        chk("t3_awsize", awsize, 0);
        chk("t3_wstrb", wstrb, 4'b1000);
        chk("t3_wdata", wdata, 32'h000000AB);
        chk("t3_wid", wid, 1);
        nxt();
        mid();
        chk("t3_awv_clr", awvalid, 0);
        chk("t3_dok_early", data_data_ok, 0);
        nxt();
        mid();
        chk("t3_dok_bv", data_data_ok, 0);
        nxt();
        mid();
        chk("t3_dok", data_data_ok, 1);

        // 4+5: AW delayed, W first; read blocked until write completes
        nxt();
        awready = 0;
        data_req = 1;
        data_wr = 1;
        data_size = 2;
        data_addr = 32'h2104;
        data_wdata = 32'h12345678;
        mid();
        chk("t4_aok", data_addr_ok, 1);
        nxt();
        data_req = 0;
        mid();
        chk("t4_awv", awvalid, 1);
        chk("t4_wv", wvalid, 1);
        chk("t4_wstrb", wstrb, 4'hF);
        chk("t4_awaddr", awaddr, 32'h2104);
        chk("t4_wdata", wdata, 32'h12345678);
        nxt();
        data_req = 1;
        data_wr = 0;
        mid();
        chk("t4_wv_clr", wvalid, 0);
        chk("t4_awv_hold", awvalid, 1);
        chk("t4_rd_blk0", data_addr_ok, 0);
        nxt();
        mid();
        chk("t4_awv_hold2", awvalid, 1);
        chk("t4_rd_blk1", data_addr_ok, 0);
        nxt();
        awready = 1;
        mid();
        chk("t4_awv_hold3", awvalid, 1);
        chk("t4_rd_blk2", data_addr_ok, 0);
        nxt();
        mid();
        chk("t4_awv_clr", awvalid, 0);
        chk("t4_rd_blk3", data_addr_ok, 0);
        chk("t4_wbeats", w_n, 2);
        nxt();
        mid();
        chk("t4_rd_blk4", data_addr_ok, 0);
        chk("t4_nok", data_data_ok, 0);
        nxt();
        mid();
        chk("t5_wok", data_data_ok, 1);
        chk("t5_rd_aok", data_addr_ok, 1);
        chk("t5_arv0", arvalid, 0);
        nxt();
        data_req = 0;
        mid();
        chk("t5_arv", arvalid, 1);
        chk("t5_arid", arid, 1);
        chk("t5_araddr", araddr, 32'h2104);
        nxt();
        nxt();
        nxt();
        nxt();
        mid();
        chk("t5_rok", data_data_ok, 1);
        chk("t5_rd", data_rdata, 32'hCAFE2104);

        // 6: reset with a read stuck in the AR slot
        nxt();
        arready = 0;
        inst_req = 1;
        inst_addr = 32'h5000;
        mid();
        chk("t6_aok", inst_addr_ok, 1);
        nxt();
        inst_req = 0;
        mid();
        chk("t6_arv", arvalid, 1);
        chk("t6_icnt1", dut.inst_rd_cnt, 1);
        #1 reset = 1;
        #1;
        chk("t6_arv_rst", arvalid, 0);
        chk("t6_awv_rst", awvalid, 0);
        chk("t6_wv_rst", wvalid, 0);
        chk("t6_icnt", dut.inst_rd_cnt, 0);
        chk("t6_dcnt", dut.data_rd_cnt, 0);
        chk("t6_wcnt", dut.wr_cnt, 0);
        nxt();
        reset = 0;
        arready = 1;
        inst_req = 1;
        inst_addr = 32'h6000;
        mid();
        chk("t6_aok_post", inst_addr_ok, 1);
        nxt();
        inst_req = 0;
        mid();
        chk("t6_arv_post", arvalid, 1);
        chk("t6_araddr", araddr, 32'h6000);
        chk("t6_arid", arid, 0);
        nxt();
        nxt();
        nxt();
        nxt();
        mid();
        chk("t6_iok", inst_data_ok, 1);
        chk("t6_ird", inst_rdata, 32'hCAFE6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
